// File: rtl/pad_input_debounce_ctrl.sv
// Pad input conditioning: two-flop synchroniser, debounce filter with programmable
// stable time, edge pulses and sticky maskable edge interrupts, one set per pad.
module pad_input_debounce_ctrl #(
  parameter int NUM_PADS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_PADS-1:0] pad_in_i,
  input  logic [NUM_PADS-1:0] en_i,
  input  logic [CNT_W-1:0]    debounce_cycles_i,
  input  logic [NUM_PADS-1:0] rise_irq_en_i,
  input  logic [NUM_PADS-1:0] fall_irq_en_i,
  input  logic [NUM_PADS-1:0] irq_clear_i,
  output logic [NUM_PADS-1:0] filtered_o,
  output logic [NUM_PADS-1:0] rise_pulse_o,
  output logic [NUM_PADS-1:0] fall_pulse_o,
  output logic [NUM_PADS-1:0] irq_pending_o,
  output logic                irq_o
);

  typedef enum logic {
    ST_STABLE,
    ST_COUNT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_PADS-1:0] sync1_q;
  logic [NUM_PADS-1:0] sync2_q;
  logic [NUM_PADS-1:0] pend_q;
  logic [NUM_PADS-1:0] pend_d;
  logic                dbc_zero;

  assign dbc_zero = (debounce_cycles_i == '0);

  // Raw pads are asynchronous to clk_i; only sync2_q is used downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_in_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;
    logic             rise_q;
    logic             fall_q;
    logic             mismatch;

    assign mismatch = (sync2_q[i] != filt_q);

    // Mismatch must persist for D+1 sampled cycles before the filtered level moves;
    // the >= compare lets a lowered D take effect on the next mismatching cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        filt_q  <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (!en_i[i]) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
          filt_q  <= sync2_q[i];
        end else begin
          case (state_q)
            ST_STABLE: begin
              if (mismatch) begin
                if (dbc_zero) begin
                  filt_q <= sync2_q[i];
                  rise_q <= sync2_q[i];
                  fall_q <= ~sync2_q[i];
                end else begin
                  cnt_q   <= CNT_ONE;
                  state_q <= ST_COUNT;
                end
              end
            end
            ST_COUNT: begin
              if (!mismatch) begin
                cnt_q   <= '0;
                state_q <= ST_STABLE;
              end else if (cnt_q >= debounce_cycles_i) begin
                filt_q  <= sync2_q[i];
                rise_q  <= sync2_q[i];
                fall_q  <= ~sync2_q[i];
                cnt_q   <= '0;
                state_q <= ST_STABLE;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            default: begin
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end
          endcase
        end
      end
    end

    assign filtered_o[i]   = filt_q;
    assign rise_pulse_o[i] = rise_q;
    assign fall_pulse_o[i] = fall_q;
  end

  // A new edge event outranks a simultaneous clear so no interrupt is lost.
  always_comb begin
    pend_d = (pend_q & ~irq_clear_i)
           | (en_i & ((rise_pulse_o & rise_irq_en_i) | (fall_pulse_o & fall_irq_en_i)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_pending_o = pend_q;
  assign irq_o         = |pend_q;

endmodule
